// File: rtl/tetris_input_pkg.sv
// Shared types and default parameters for the tetris player-input front end.
package tetris_input_pkg;

  typedef enum logic [1:0] {
    STICK_CENTER = 2'b00,
    STICK_LEFT   = 2'b01,
    STICK_RIGHT  = 2'b10
  } stick_e;

  localparam int unsigned ADC_W_DEF        = 12;
  localparam int unsigned LO_THRESH_DEF    = 1100;
  localparam int unsigned HI_THRESH_DEF    = 2200;
  localparam int unsigned HYST_DEF         = 64;
  localparam int unsigned NUM_BTN_DEF      = 2;
  localparam int unsigned DEBOUNCE_CYC_DEF = 500000;
  localparam int unsigned DAS_DELAY_DEF    = 8000000;
  localparam int unsigned DAS_RATE_DEF     = 2500000;
  localparam int unsigned CHORD_CYC_DEF    = 50000000;

  // Counter width able to hold n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// One pushbuttonbutton: 2-FF synchroniser, debounce counter, debounced level and rising-edge press pulse.
module input_debounce
  import tetris_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic suppress,
  output logic level,
  output logic press
);

  localparam int unsigned         CNT_W    = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  // Level only follows the synchronised input after it has disagreed for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      press     <= 1'b0;
      if (sync_q != level) begin
        if (cnt == CNT_LAST) begin
          level <= ~level;
          cnt   <= '0;
          press <= ~level & ~suppress;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Player-input front end: hysteretic joystick classifier with DAS auto-repeat and debounced buttons.
// Optional all-buttons chord reset is built only when INPUT_CHORD_RESET_EN is defined.
module tetris_input_ctrl
  import tetris_input_pkg::*;
#(
  parameter int unsigned ADC_W        = ADC_W_DEF,
  parameter int unsigned LO_THRESH    = LO_THRESH_DEF,
  parameter int unsigned HI_THRESH    = HI_THRESH_DEF,
  parameter int unsigned HYST         = HYST_DEF,
  parameter int unsigned NUM_BTN      = NUM_BTN_DEF,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned DAS_DELAY    = DAS_DELAY_DEF,
  parameter int unsigned DAS_RATE     = DAS_RATE_DEF,
  parameter int unsigned CHORD_CYC    = CHORD_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADC_W-1:0]   adc_value,
  input  logic               adc_valid,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [1:0]         stick_state,
  output logic               move_left,
  output logic               move_right,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic               chord_reset
);

  localparam int unsigned DAS_MAX = (DAS_DELAY > DAS_RATE) ? DAS_DELAY : DAS_RATE;
  localparam int unsigned CNT_W   = cnt_width(DAS_MAX);

  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(DAS_RATE - 1);

  localparam logic [ADC_W-1:0] LO_ENTER = ADC_W'(LO_THRESH);
  localparam logic [ADC_W-1:0] HI_ENTER = ADC_W'(HI_THRESH);
  localparam logic [ADC_W-1:0] LO_EXIT  = ADC_W'(LO_THRESH + HYST);
  localparam logic [ADC_W-1:0] HI_EXIT  = ADC_W'(HI_THRESH - HYST);

  // Exit windows must not overlap, and every count parameter must be at least one.
  if ((LO_THRESH + 2 * HYST >= HI_THRESH) || (HI_THRESH >= (64'd1 << ADC_W)) ||
      (NUM_BTN < 1) || (DEBOUNCE_CYC < 1) || (DAS_DELAY < 1) || (DAS_RATE < 1) ||
      (CHORD_CYC < 1)) begin : g_bad_params
    $error("tetris_input_ctrl: illegal parameter set");
  end

  stick_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             move_left_d, move_right_d;
  logic             press_block;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= STICK_CENTER;
      cnt_q      <= '0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      move_left  <= move_left_d;
      move_right <= move_right_d;
    end
  end

  // Stick classification runs on valid samples only; the repeat counter runs every cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    move_left_d  = 1'b0;
    move_right_d = 1'b0;

    if (adc_valid) begin
      case (state_q)
        STICK_CENTER: begin
          if (adc_value < LO_ENTER)      state_d = STICK_LEFT;
          else if (adc_value > HI_ENTER) state_d = STICK_RIGHT;
        end
        STICK_LEFT: begin
          if (adc_value > HI_ENTER)      state_d = STICK_RIGHT;
          else if (adc_value >= LO_EXIT) state_d = STICK_CENTER;
        end
        STICK_RIGHT: begin
          if (adc_value < LO_ENTER)      state_d = STICK_LEFT;
          else if (adc_value <= HI_EXIT) state_d = STICK_CENTER;
        end
        default: state_d = STICK_CENTER;
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == STICK_LEFT) begin
        move_left_d = 1'b1;
        cnt_d       = DELAY_LOAD;
      end else if (state_d == STICK_RIGHT) begin
        move_right_d = 1'b1;
        cnt_d        = DELAY_LOAD;
      end
    end else if (state_q != STICK_CENTER) begin
      if (cnt_q == '0) begin
        cnt_d        = RATE_LOAD;
        move_left_d  = (state_q == STICK_LEFT);
        move_right_d = (state_q == STICK_RIGHT);
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  assign stick_state = state_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    input_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .raw      (btn_raw[i]),
      .suppress (press_block),
      .level    (btn_level[i]),
      .press    (btn_press[i])
    );
  end

`ifdef INPUT_CHORD_RESET_EN
  localparam int unsigned            CHORD_W    = cnt_width(CHORD_CYC);
  localparam logic [CHORD_W-1:0]     CHORD_LAST = CHORD_W'(CHORD_CYC - 1);

  logic [CHORD_W-1:0] chord_cnt;
  logic               chord_q;

  // Chord holds once reached until any debounced button drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      chord_cnt <= '0;
      chord_q   <= 1'b0;
    end else if (&btn_level) begin
      if (chord_cnt == CHORD_LAST) chord_q   <= 1'b1;
      else                         chord_cnt <= chord_cnt + CHORD_W'(1);
    end else begin
      chord_cnt <= '0;
      chord_q   <= 1'b0;
    end
  end

  assign chord_reset = chord_q;
  assign press_block = chord_q;
`else
  assign chord_reset = 1'b0;
  assign press_block = 1'b0;
`endif

endmodule
